// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad digit controller.
// Holds the FSM state type, the key legend table and the row-priority helper.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    // Key legend indexed [row][col]; row 3 carries the E/0/F/D bottom row.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Lowest-numbered active-low row wins when several rows are pulled down.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
// Both stages reset to RESET_VAL so idle (pulled-up) inputs read as inactive.
module sync2 #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_digit_ctrl.sv
// Scans a 4x4 active-low keypad, debounces press and release, and shifts each
// accepted key into a two-digit history (s1 newest, s2 previous) for the display.
module keypad_digit_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 4096,
    parameter int DEBOUNCE_CNT = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] s1,
    output logic [3:0] s2,
    output logic       key_valid
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state, state_n;
    logic [1:0]       col, col_n;
    logic [1:0]       row, row_n;
    logic [3:0]       pat, pat_n;
    logic [CNT_W-1:0] dwell, dwell_n;
    logic [CNT_W-1:0] deb, deb_n;
    logic [3:0]       s1_n, s2_n;
    logic             key_valid_n;
    logic [3:0]       rsync;

    sync2 #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rsync)
    );

    assign cols = ~(4'b0001 << col);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            col       <= 2'd0;
            row       <= 2'd0;
            pat       <= 4'hF;
            dwell     <= '0;
            deb       <= '0;
            s1        <= 4'h0;
            s2        <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            col       <= col_n;
            row       <= row_n;
            pat       <= pat_n;
            dwell     <= dwell_n;
            deb       <= deb_n;
            s1        <= s1_n;
            s2        <= s2_n;
            key_valid <= key_valid_n;
        end
    end

    // Detection takes priority over the column advance so a press seen on the
    // last dwell cycle is still attributed to the column that produced it.
    always_comb begin
        state_n     = state;
        col_n       = col;
        row_n       = row;
        pat_n       = pat;
        dwell_n     = dwell;
        deb_n       = deb;
        s1_n        = s1;
        s2_n        = s2;
        key_valid_n = 1'b0;

        case (state)
            SCAN: begin
                if (rsync != 4'hF) begin
                    row_n   = lowest_low_row(rsync);
                    pat_n   = rsync;
                    deb_n   = '0;
                    state_n = PRESS_DB;
                end else if (dwell == DWELL_LAST) begin
                    dwell_n = '0;
                    col_n   = col + 2'd1;
                end else begin
                    dwell_n = dwell + CNT_ONE;
                end
            end

            PRESS_DB: begin
                if (rsync != pat) begin
                    state_n = SCAN;
                    col_n   = col + 2'd1;
                    dwell_n = '0;
                end else if (deb == DB_LAST) begin
                    s2_n        = s1;
                    s1_n        = KEYMAP[row][col];
                    key_valid_n = 1'b1;
                    deb_n       = '0;
                    state_n     = HELD;
                end else begin
                    deb_n = deb + CNT_ONE;
                end
            end

            // Only the accepted key's row matters here; extra rows are ignored.
            HELD: begin
                if (rsync[row]) begin
                    deb_n   = '0;
                    state_n = RELEASE_DB;
                end
            end

            RELEASE_DB: begin
                if (!rsync[row]) begin
                    deb_n   = '0;
                    state_n = HELD;
                end else if (deb == DB_LAST) begin
                    deb_n   = '0;
                    dwell_n = '0;
                    col_n   = col + 2'd1;
                    state_n = SCAN;
                end else begin
                    deb_n = deb + CNT_ONE;
                end
            end

            default: state_n = SCAN;
        endcase
    end

endmodule

// File: tb/tb_keypad_digit_ctrl.sv
// Bench for keypad_digit_ctrl: a physical keypad model closes rows only while
// the pressed key's column is driven; expected digits come from the key legend.
module tb_keypad_digit_ctrl;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;
    localparam int WAIT_LIMIT   = 300;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       key_valid;

    logic [3:0] pressed [4];
    string      keyChars = "123A456B789CE0FD";

    int vectors = 0;
    int miscompares = 0;
    int pulseCount = 0;
    int longPulse = 0;
    int badChange = 0;
    int colsBad = 0;
    int heldBase = 0;
    logic [3:0] prevS1 = 4'h0;
    logic [3:0] prevS2 = 4'h0;
    logic       prevKv = 1'b0;
    logic [3:0] expS1 = 4'h0;
    logic [3:0] expS2 = 4'h0;

    always #5 clk = ~clk;

    keypad_digit_ctrl #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .s1        (s1),
        .s2        (s2),
        .key_valid (key_valid)
    );

    // A key pulls its row low only while its column is being driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (|(pressed[r] & ~cols)) rows[r] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (key_valid) pulseCount <= pulseCount + 1;
        if (key_valid && prevKv) longPulse <= longPulse + 1;
        if (reset && !key_valid && (s1 !== prevS1 || s2 !== prevS2)) badChange <= badChange + 1;
        if (!$onehot(~cols)) colsBad <= colsBad + 1;
        prevS1 <= s1;
        prevS2 <= s2;
        prevKv <= key_valid;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] colMask(input int c);
        return ~(4'b0001 << (c % 4));
    endfunction

    function automatic logic [3:0] keyDigit(input int r, input int c);
        byte ch;
        ch = keyChars[r * 4 + c];
        if (ch <= 8'sh39) return 4'(ch - 8'sh30);
        return 4'(ch - 8'sh41 + 8'sd10);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Returns on the first cycle a fresh dwell of column c begins.
    task automatic waitColumnStart(input int c);
        int n;
        n = 0;
        while (cols == colMask(c) && n < 64) begin tick(1); n++; end
        while (cols != colMask(c) && n < 64) begin tick(1); n++; end
        checkOutput("col_reached", cols, colMask(c));
    endtask

    task automatic pressKey(input int r, input int c);
        int n;
        n = 0;
        heldBase = pulseCount;
        pressed[r][c] = 1'b1;
        while (pulseCount == heldBase && n < WAIT_LIMIT) begin tick(1); n++; end
        checkOutput("accept_pulse", pulseCount - heldBase, 1);
        expS2 = expS1;
        expS1 = keyDigit(r, c);
        checkOutput("s1_on_accept", s1, expS1);
        checkOutput("s2_on_accept", s2, expS2);
    endtask

    task automatic applyStimulus(input int r, input int c, input int hold, input int relWait);
        pressKey(r, c);
        tick(hold);
        checkOutput("cols_frozen", cols, colMask(c));
        checkOutput("pulses_while_held", pulseCount - heldBase, 1);
        pressed[r][c] = 1'b0;
        tick(relWait);
        checkOutput("pulses_after_release", pulseCount - heldBase, 1);
        checkOutput("s1_after_release", s1, expS1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int r;
        int c;
        for (int i = 0; i < 4; i++) pressed[i] = 4'h0;
        tick(3);
        checkOutput("reset_cols", cols, 4'b1110);
        checkOutput("reset_s1", s1, 4'h0);
        checkOutput("reset_s2", s2, 4'h0);
        checkOutput("reset_key_valid", key_valid, 1'b0);

        // Idle scan: column k/SCAN_DIV after k clock edges out of reset.
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            checkOutput("scan_cols", cols, colMask((k / SCAN_DIV) % 4));
            tick(1);
        end
        checkOutput("idle_no_pulse", pulseCount, 0);

        applyStimulus(1, 2, 20, 20);
        applyStimulus(3, 1, 10, 20);

        // Bounce on row 1 / col 0: low 3, high 2, low 3.
        waitColumnStart(0);
        base = pulseCount;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) checkOutput("bounce_next_col", cols, colMask(1));
            pressed[1][0] = (k < 3 || k >= 5);
            tick(1);
        end
        pressed[1][0] = 1'b0;
        tick(20);
        checkOutput("bounce_no_pulse", pulseCount - base, 0);

        // Held "1" with an extra row and a short release glitch.
        pressKey(0, 0);
        pressed[2][0] = 1'b1;
        tick(12);
        checkOutput("extra_row_no_pulse", pulseCount - heldBase, 1);
        checkOutput("extra_row_cols", cols, 4'b1110);
        pressed[2][0] = 1'b0;
        tick(4);
        pressed[0][0] = 1'b0;
        tick(3);
        pressed[0][0] = 1'b1;
        tick(15);
        checkOutput("glitch_no_pulse", pulseCount - heldBase, 1);
        checkOutput("glitch_cols", cols, 4'b1110);
        pressed[0][0] = 1'b0;
        tick(20);
        checkOutput("glitch_release", pulseCount - heldBase, 1);
        checkOutput("glitch_s1", s1, 4'h1);

        // Reset while "A" is being debounced; the held key is accepted afterwards.
        waitColumnStart(3);
        base = pulseCount;
        pressed[0][3] = 1'b1;
        tick(5);
        reset = 1'b0;
        #1;
        checkOutput("midreset_s1", s1, 4'h0);
        checkOutput("midreset_s2", s2, 4'h0);
        checkOutput("midreset_kv", key_valid, 1'b0);
        checkOutput("midreset_cols", cols, 4'b1110);
        checkOutput("midreset_no_pulse", pulseCount - base, 0);
        expS1 = 4'h0;
        expS2 = 4'h0;
        tick(3);
        reset = 1'b1;
        pressed[0][3] = 1'b0;
        applyStimulus(0, 3, 20, 20);
        checkOutput("midreset_accept_s1", s1, 4'hA);

        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            tick($urandom_range(0, 10));
            if ($urandom_range(0, 3) == 0) begin
                base = pulseCount;
                pressed[r][c] = 1'b1;
                tick($urandom_range(1, 5));
                pressed[r][c] = 1'b0;
                tick(16);
                checkOutput("short_press_no_pulse", pulseCount - base, 0);
                checkOutput("short_press_s1", s1, expS1);
            end else begin
                applyStimulus(r, c, $urandom_range(0, 30), $urandom_range(16, 30));
            end
        end

        checkOutput("digits_change_only_on_accept", badChange, 0);
        checkOutput("cols_one_low", colsBad, 0);
        checkOutput("pulse_one_cycle", longPulse, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_digit_ctrl.md
KEYPAD_DIGIT_CTRL -- requirements
Module: keypad_digit_ctrl

Interface
REQ-001 SHALL have parameter: SCAN_DIV, 4096, clk cycles each column is driven during scanning (>=4).
REQ-002 SHALL have parameter: DEBOUNCE_CNT, 65536, consecutive stable cycles required to accept a press or release (>=2).
REQ-003 SHALL have port: clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: rows  input  4  keypad rows, active-low (pulled up), asynchronous to clk.
REQ-006 SHALL have port: cols  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port: s1  output  4  most recent accepted key (hex), feeds the dual display s1 input.
REQ-008 SHALL have port: s2  output  4  previously accepted key (hex), feeds the dual display s2 input.
REQ-009 SHALL have port: key_valid  output  1  one-cycle pulse on each accepted key.

Function
REQ-010 SHALL pass rows through a 2-flop synchronizer (reset value 4'hF); all decisions use the synchronized value rsync; input-to-decision latency 2 cycles.
REQ-011 SHALL implement FSM states SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-012 SCAN: drive column index c low; dwell counter advances each cycle; after SCAN_DIV cycles c increments, wrapping 3->0.
REQ-013 SCAN: when rsync != 4'hF, SHALL freeze c, capture row index r = lowest-index low bit of rsync and pattern p = rsync, clear debounce counter, enter PRESS_DB.
REQ-014 PRESS_DB: each cycle rsync == p increments counter; rsync != p returns to SCAN with c advanced to next column (wrap) and dwell counter cleared.
REQ-015 PRESS_DB: counter reaching DEBOUNCE_CNT SHALL, in one cycle, set s2<=s1, s1<=KEYMAP[r][c], pulse key_valid, enter HELD.
REQ-016 KEYMAP (row,col): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E,0,F,D.
REQ-017 HELD: column stays frozen; additional rows going low SHALL be ignored (no new key, no pulse); when rsync[r] goes high, clear counter, enter RELEASE_DB.
REQ-018 RELEASE_DB: rsync[r] high for DEBOUNCE_CNT consecutive cycles -> SCAN at next column; rsync[r] low at any time -> HELD without counter carry-over.
REQ-019 key_valid SHALL be high only in the single acceptance cycle; holding a key never produces a second pulse.
REQ-020 s1/s2 SHALL change only on acceptance; display digits stay stable otherwise.
REQ-021 Counters SHALL be sized $clog2(max(SCAN_DIV,DEBOUNCE_CNT)+1) and never wrap.

Reset
REQ-022 reset low SHALL asynchronously force: state SCAN, c=0, cols=4'b1110, s1=4'h0, s2=4'h0, key_valid=0, counters 0, synchronizer 4'hF.
REQ-023 reset asserted mid-debounce or while HELD SHALL discard the pending key; after release, a still-held key SHALL be re-debounced and accepted once.

Structure
REQ-024 A shared package keypad_pkg SHALL hold the state enum type and the KEYMAP constant table.
REQ-025 The synchronizer SHALL be a separate sub-module sync2 (parameterized width); FSM, counters and digit registers reside in keypad_digit_ctrl.
REQ-026 Outputs s1, s2 SHALL connect unmodified to the existing dual seven-segment driver; no display logic resides here.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-027 Reset release, rows=4'hF -> cols cycles 1110,1101,1011,0111,1110 every 4 cycles; s1=s2=0, key_valid never high.
REQ-028 Press r1 when col 2 driven (rows=4'b1101 while cols=1011), hold 20 cycles -> exactly one key_valid pulse, s1=4'h6, s2=4'h0; cols frozen at 1011 until release.
REQ-029 Then press r3/col1 key, hold, release -> s1=4'h0, s2=4'h6; one pulse per press.
REQ-030 Bounce: rows low 3 cycles, high 2, low 3 -> no key_valid, scanning resumes at next column.
REQ-031 While HELD on r0/col0 ("1"), also press r2 -> no new pulse; release r0 glitching high 3 cycles then low -> remains HELD, no pulse.
REQ-032 reset asserted during PRESS_DB of "A" -> outputs at reset values immediately; key still held after release -> accepted once, s1=4'hA.
